// File: rtl/vedic_seq_mult_if.sv
// vedic_seq_mult_if: operand/result handshake bundle for vedic_seq_mult.
// master = operand source + result consumer, slave = the multiplier.
// Signals: in_valid/in_ready/a/b (operands), out_valid/out_ready/prod (result), busy.
interface vedic_seq_mult_if #(
   parameter int WIDTH = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] prod;
   logic               busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, prod, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, prod, busy
   );
endinterface

// File: rtl/vedic_seq_mult.sv
// vedic_seq_mult: sequential WIDTH x WIDTH multiplier, one 2-bit multiplier digit per clock.
// Latency: out_valid rises WIDTH/2 edges after the accepting edge; one result per WIDTH/2+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, prod held until next result.
// Ports: clk, rst (async active-high), bus (slave modport of vedic_seq_mult_if).
// Optional: define VEDIC_SEQ_MULT_SIGNED_EN for two's complement operands (magnitude multiply + sign fix).
module vedic_seq_mult #(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   vedic_seq_mult_if.slave bus
);
   localparam int ITER = WIDTH / 2;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam int PW   = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [PW-1:0]    r_acc;
   logic [PW-1:0]    r_prod;
   logic [CW-1:0]    r_cnt;

   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_busy;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] w_b_sh;
   logic [1:0]       w_digit;
   logic [WIDTH+1:0] w_pp;
   logic [PW-1:0]    w_acc_nxt;
   logic [PW-1:0]    w_prod_nxt;
   logic [WIDTH-1:0] w_a_lat;
   logic [WIDTH-1:0] w_b_lat;

   // Current digit of b: shift by 2*cnt rather than a variable part-select.
   assign w_b_sh  = r_b >> {r_cnt, 1'b0};
   assign w_digit = w_b_sh[1:0];
   assign w_last  = (r_cnt == CW'(ITER - 1));

   // 2x2 vedic cell generalised: partial product is 0, a, 2a or 3a.
   always_comb begin
      w_pp = '0;
      case (w_digit)
         2'd1:    w_pp = {2'b00, r_a};
         2'd2:    w_pp = {1'b0, r_a, 1'b0};
         2'd3:    w_pp = {2'b00, r_a} + {1'b0, r_a, 1'b0};
         default: w_pp = '0;
      endcase
   end

   assign w_acc_nxt = r_acc + (PW'(w_pp) << {r_cnt, 1'b0});

`ifdef VEDIC_SEQ_MULT_SIGNED_EN
   logic r_sign;

   // Magnitudes; -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
   assign w_a_lat    = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
   assign w_b_lat    = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
   assign w_prod_nxt = r_sign ? (~w_acc_nxt + PW'(1)) : w_acc_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sign <= 1'b0;
      end else if (w_accept) begin
         r_sign <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      end
   end
`else
   assign w_a_lat    = bus.a;
   assign w_b_lat    = bus.b;
   assign w_prod_nxt = w_acc_nxt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_state_nxt = S_CALC;
         end
         S_CALC: begin
            w_busy = 1'b1;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_busy      = 1'b1;
            w_out_valid = 1'b1;
            if (bus.out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_accept = w_in_ready & bus.in_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_prod <= '0;
      end else if (w_accept) begin
         r_a   <= w_a_lat;
         r_b   <= w_b_lat;
         r_acc <= '0;
         r_cnt <= '0;
      end else if (r_state == S_CALC) begin
         r_acc <= w_acc_nxt;
         r_cnt <= r_cnt + CW'(1);
         // Result register only moves on the CALC->DONE edge.
         if (w_last) r_prod <= w_prod_nxt;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.busy      = w_busy;
   assign bus.prod      = r_prod;
endmodule

// File: tb/tb_vedic_seq_mult.sv
module tb_vedic_seq_mult;
   logic clk = 1'b0;
   logic rst;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   vedic_seq_mult_if #(.WIDTH(8))  if8 ();
   vedic_seq_mult_if #(.WIDTH(2))  if2 ();
   vedic_seq_mult_if #(.WIDTH(16)) if16 ();

   vedic_seq_mult #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
   vedic_seq_mult #(.WIDTH(2))  u_dut2  (.clk(clk), .rst(rst), .bus(if2));
   vedic_seq_mult #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

   function automatic logic [3:0] ref2(input logic [1:0] x, input logic [1:0] y);
`ifdef VEDIC_SEQ_MULT_SIGNED_EN
      logic [3:0] sx, sy;
      sx = {{2{x[1]}}, x};
      sy = {{2{y[1]}}, y};
      return sx * sy;
`else
      return {2'b00, x} * {2'b00, y};
`endif
   endfunction

   function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y);
`ifdef VEDIC_SEQ_MULT_SIGNED_EN
      logic [31:0] sx, sy;
      sx = {{16{x[15]}}, x};
      sy = {{16{y[15]}}, y};
      return sx * sy;
`else
      return {16'h0, x} * {16'h0, y};
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one operation with out_ready high; report product and edges until out_valid.
   task automatic do_op8(input logic [7:0] a_i, input logic [7:0] b_i,
                         output logic [15:0] p, output int lat);
      if8.a = a_i; if8.b = b_i; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
      step();
      if8.in_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (if8.out_valid) begin lat = k; break; end
      end
      p = if8.prod;
      step();
   endtask

   task automatic do_op2(input logic [1:0] a_i, input logic [1:0] b_i,
                         output logic [3:0] p, output int lat);
      if2.a = a_i; if2.b = b_i; if2.in_valid = 1'b1; if2.out_ready = 1'b1;
      step();
      if2.in_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (if2.out_valid) begin lat = k; break; end
      end
      p = if2.prod;
      step();
   endtask

   task automatic do_op16(input logic [15:0] a_i, input logic [15:0] b_i,
                          output logic [31:0] p, output int lat);
      if16.a = a_i; if16.b = b_i; if16.in_valid = 1'b1; if16.out_ready = 1'b1;
      step();
      if16.in_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (if16.out_valid) begin lat = k; break; end
      end
      p = if16.prod;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (if8.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", if8.in_ready); end
      n_total++; if (if8.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", if8.out_valid); end
      n_total++; if (if8.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", if8.busy); end
      n_total++; if (if8.prod !== 16'h0000) begin n_bad++; $display("FAIL reset_prod: got %h want 0000", if8.prod); end
      n_total++; if (if16.prod !== 32'h0) begin n_bad++; $display("FAIL reset_prod16: got %h want 0", if16.prod); end
      #2 rst = 1'b0;
      step();
   endtask

   task automatic test_latency();
      if8.a = 8'd3; if8.b = 8'd3; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
      step();
      if8.in_valid = 1'b0;
      n_total++; if (if8.in_ready !== 1'b0) begin n_bad++; $display("FAIL lat_in_ready_calc: got %b want 0", if8.in_ready); end
      n_total++; if (if8.busy !== 1'b1) begin n_bad++; $display("FAIL lat_busy_calc: got %b want 1", if8.busy); end
      for (int k = 1; k <= 3; k++) begin
         step();
         n_total++; if (if8.out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early_valid_%0d: got %b want 0", k, if8.out_valid); end
         n_total++; if (if8.in_ready !== 1'b0) begin n_bad++; $display("FAIL lat_in_ready_%0d: got %b want 0", k, if8.in_ready); end
      end
      step();
      n_total++; if (if8.out_valid !== 1'b1) begin n_bad++; $display("FAIL lat_valid_e4: got %b want 1", if8.out_valid); end
      n_total++; if (if8.prod !== 16'h0009) begin n_bad++; $display("FAIL lat_prod: got %h want 0009", if8.prod); end
      n_total++; if (if8.in_ready !== 1'b0) begin n_bad++; $display("FAIL lat_in_ready_done: got %b want 0", if8.in_ready); end
      step();
      n_total++; if (if8.out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_valid_drop: got %b want 0", if8.out_valid); end
      n_total++; if (if8.in_ready !== 1'b1) begin n_bad++; $display("FAIL lat_idle_ready: got %b want 1", if8.in_ready); end
      n_total++; if (if8.busy !== 1'b0) begin n_bad++; $display("FAIL lat_idle_busy: got %b want 0", if8.busy); end
   endtask

   task automatic test_directed();
      logic [7:0]  va [4];
      logic [7:0]  vb [4];
      logic [15:0] vp [4];
      logic [15:0] p;
      int          lat;
`ifdef VEDIC_SEQ_MULT_SIGNED_EN
      va = '{8'hFD, 8'h80, 8'h80, 8'hFF};
      vb = '{8'h05, 8'h80, 8'h7F, 8'hFF};
      vp = '{16'hFFF1, 16'h4000, 16'hC080, 16'h0001};
`else
      va = '{8'hFF, 8'h00, 8'hA5, 8'h07};
      vb = '{8'hFF, 8'hA5, 8'h01, 8'h06};
      vp = '{16'hFE01, 16'h0000, 16'h00A5, 16'h002A};
`endif
      for (int i = 0; i < 4; i++) begin
         do_op8(va[i], vb[i], p, lat);
         n_total++; if (p !== vp[i]) begin n_bad++; $display("FAIL directed_prod_%0d: got %h want %h", i, p, vp[i]); end
         n_total++; if (lat !== 4) begin n_bad++; $display("FAIL directed_lat_%0d: got %0d want 4", i, lat); end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      if8.a = 8'd12; if8.b = 8'd10; if8.in_valid = 1'b1; if8.out_ready = 1'b0;
      step();
      if8.in_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (if8.out_valid) begin lat = k; break; end
      end
      n_total++; if (lat !== 4) begin n_bad++; $display("FAIL bp_lat: got %0d want 4", lat); end
      // A new request while stalled in DONE must be ignored.
      if8.a = 8'd99; if8.b = 8'd99; if8.in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         n_total++; if (if8.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_%0d: got %b want 1", k, if8.out_valid); end
         n_total++; if (if8.prod !== 16'd120) begin n_bad++; $display("FAIL bp_prod_%0d: got %0d want 120", k, if8.prod); end
         n_total++; if (if8.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_%0d: got %b want 0", k, if8.in_ready); end
      end
      if8.in_valid = 1'b0;
      if8.out_ready = 1'b1;
      step();
      n_total++; if (if8.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b want 0", if8.out_valid); end
      n_total++; if (if8.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", if8.in_ready); end
      step();
      n_total++; if (if8.busy !== 1'b0) begin n_bad++; $display("FAIL bp_idle_busy: got %b want 0", if8.busy); end
      n_total++; if (if8.prod !== 16'd120) begin n_bad++; $display("FAIL bp_idle_prod: got %0d want 120", if8.prod); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] p;
      int          lat;
      if8.a = 8'd200; if8.b = 8'd200; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
      step();
      if8.in_valid = 1'b0;
      step();
      #3 rst = 1'b1;
      #1;
      n_total++; if (if8.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", if8.busy); end
      n_total++; if (if8.in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 1", if8.in_ready); end
      n_total++; if (if8.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b want 0", if8.out_valid); end
      n_total++; if (if8.prod !== 16'h0000) begin n_bad++; $display("FAIL rstmid_prod: got %h want 0000", if8.prod); end
      #1 rst = 1'b0;
      do_op8(8'd7, 8'd6, p, lat);
      n_total++; if (p !== 16'd42) begin n_bad++; $display("FAIL rstmid_after_prod: got %0d want 42", p); end
      n_total++; if (lat !== 4) begin n_bad++; $display("FAIL rstmid_after_lat: got %0d want 4", lat); end
   endtask

   task automatic test_w2_exhaustive();
      logic [3:0] p;
      int         lat;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            do_op2(2'(i), 2'(j), p, lat);
            n_total++; if (p !== ref2(2'(i), 2'(j))) begin n_bad++; $display("FAIL w2_prod_%0d_%0d: got %h want %h", i, j, p, ref2(2'(i), 2'(j))); end
            n_total++; if (lat !== 1) begin n_bad++; $display("FAIL w2_lat_%0d_%0d: got %0d want 1", i, j, lat); end
         end
      end
   endtask

   task automatic test_w16_random();
      logic [15:0] x, y;
      logic [31:0] p;
      int          lat;
      for (int i = 0; i < 1002; i++) begin
         if (i == 0) begin x = 16'hFFFF; y = 16'hFFFF; end
         else if (i == 1) begin x = 16'h8000; y = 16'h8000; end
         else begin x = 16'($urandom); y = 16'($urandom); end
         do_op16(x, y, p, lat);
         n_total++; if (p !== ref16(x, y)) begin n_bad++; $display("FAIL w16_prod_%0d: a=%h b=%h got %h want %h", i, x, y, p, ref16(x, y)); end
         n_total++; if (lat !== 8) begin n_bad++; $display("FAIL w16_lat_%0d: got %0d want 8", i, lat); end
      end
   endtask

   initial begin
      rst = 1'b1;
      if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.out_ready  = 1'b1;
      if2.in_valid  = 1'b0; if2.a  = '0; if2.b  = '0; if2.out_ready  = 1'b1;
      if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.out_ready = 1'b1;
      test_reset();
      test_latency();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_w2_exhaustive();
      test_w16_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/vedic_seq_mult.md
Name: vedic_seq_mult

Overview:
- Parametrised, multi-cycle multiplier; generalises the 2x2 vedic cell to WIDTH x WIDTH operands.
- Retires one 2-bit multiplier digit per clock: partial product a*digit (0, a, 2a or 3a), shifted and accumulated.
- Valid/ready handshake on input and output.
- Sits between operand sources and datapath consumers where area matters more than throughput.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2. Product is 2*WIDTH bits. Iterations ITER = WIDTH/2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a, b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  prod valid
- out_ready  input  1  consumer accepts prod
- prod  output  2*WIDTH  product
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset (async, active-high, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, prod=0, accumulator=0, digit counter=0. Reset mid-CALC or mid-DONE discards the operation with no output.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b into internal registers; acc=0; cnt=0; go to CALC.
  - Operand inputs are ignored at all other times.
- CALC:
  - in_ready=0, busy=1.
  - Each cycle: d = b_reg[2*cnt+1 : 2*cnt]; pp = a_reg*d (WIDTH+2 bits); acc += pp << (2*cnt), computed at 2*WIDTH bits; cnt++.
  - After the cycle with cnt == ITER-1, go to DONE. prod is loaded with the final acc on that same edge.
- DONE:
  - out_valid=1; prod held stable.
  - On out_valid&out_ready: out_valid=0 next cycle; go to IDLE.
  - Without out_ready, stays indefinitely with prod unchanged.
- Latency: acceptance edge E; out_valid rises after edge E+ITER (WIDTH=8: 4 cycles).
- Throughput: one result per ITER+2 cycles minimum. No back-to-back acceptance: in_ready only in IDLE.
- Arithmetic:
  - Unsigned by default.
  - acc never overflows 2*WIDTH bits, since max product is (2^WIDTH-1)^2.
- prod changes only on the CALC→DONE edge or reset; otherwise it holds the last result, including in IDLE.
- WIDTH=2 degenerates to a single CALC cycle; the result must match the 2x2 vedic cell truth table.

Optional Feature:
- Macro: VEDIC_SEQ_MULT_SIGNED_EN.
- When defined, a and b are two's complement:
  - On acceptance, latch |a|, |b| (WIDTH-bit unsigned; |-2^(WIDTH-1)| = 2^(WIDTH-1) fits) and sign = a[MSB]^b[MSB].
  - Run the unchanged unsigned CALC.
  - On the CALC→DONE edge, prod = sign ? -acc : acc (2*WIDTH-bit two's complement).
  - Latency unchanged.
- When undefined: purely unsigned; no sign logic synthesised.

Test Plan:
- WIDTH=8, unsigned, out_ready=1: a=3, b=3 accepted at edge E → out_valid high after E+4, prod=16'h0009; in_ready low from E+1 until return to IDLE.
- WIDTH=8: a=255, b=255 → prod=16'hFE01 (65025); a=0, b=8'hA5 → prod=0; a=8'hA5, b=1 → prod=16'h00A5.
- Backpressure: a=12, b=10, out_ready=0 for 10 cycles after out_valid → prod=120 stable, out_valid held, in_ready=0, a new in_valid ignored. Raise out_ready → one transfer, then IDLE with in_ready=1.
- Reset mid-operation: assert rst asynchronously (not on a clock edge) during the 2nd CALC cycle → outputs immediately at reset values. A following a=7, b=6 → prod=42 with full 4-cycle latency.
- WIDTH=2 exhaustive (all 16 pairs) and WIDTH=16 random ≥1000 pairs against a reference model → exact match.
- VEDIC_SEQ_MULT_SIGNED_EN, WIDTH=8: a=-3, b=5 → prod=16'hFFF1; a=-128, b=-128 → prod=16'h4000; a=-128, b=127 → prod=16'hC080.
